mac_result_serializer: RTL and testbench

Producer-side partner of the done-pulse counter in the systolic MAC datapath. On a start strobe it captures NUM_VALS parallel MAC results and emits them one per valid/ready handshake on a serial result port. For every accepted value it issues a one-cycle done pulse, so the downstream counter sees exactly NUM_VALS pulses per burst and raises en_y.

---
 rtl/mac_result_serializer.sv | 89 ++++++++
 tb/tb_mac_result_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_serializer.sv
// Captures NUM_VALS parallel MAC results on start and streams them out one
// word per valid/ready handshake, pulsing done once per accepted word.
module mac_result_serializer #(
  parameter int NUM_VALS = 7,
  parameter int DATA_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_VALS*DATA_W-1:0] data_in,
  output logic                       busy,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       done,
  output logic                       state_dbg
);

  localparam int IDX_W = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           next_idx;
  logic [NUM_VALS*DATA_W-1:0] shadow;
  logic                       hs;

  // Valid/ready: a word transfers on a rising edge where out_valid and
  // out_ready are both high; once raised, out_valid, out_data and out_last
  // stay fixed until that transfer happens.
  always_comb begin
    hs       = out_valid & out_ready;
    next_idx = idx + IDX_W'(1);
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= hs;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            idx       <= '0;
            shadow    <= data_in;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= data_in[0 +: DATA_W];
            out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (hs) begin
            if (idx == LAST_IDX) begin
              state     <= IDLE;
              idx       <= '0;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              idx      <= next_idx;
              out_data <= shadow[int'(next_idx)*DATA_W +: DATA_W];
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: the driver queues expected words,
// an independent negedge monitor checks every handshake, hold and done pulse.
module tb_mac_result_serializer;

  localparam int NUM_VALS = 7;
  localparam int DATA_W   = 16;
  localparam int W        = DATA_W + 1;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       start = 1'b0;
  logic [NUM_VALS*DATA_W-1:0] data_in = '0;
  logic                       out_ready = 1'b0;
  logic                       busy;
  logic [DATA_W-1:0]          out_data;
  logic                       out_valid;
  logic                       out_last;
  logic                       done;
  logic                       state_dbg;

  mac_result_serializer #(.NUM_VALS(NUM_VALS), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int en_y_cnt = 0;
  int en_ctr = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected queue on every handshake, checks hold
  // stability under backpressure, and that done trails each handshake.
  initial begin
    logic hs_prev, pv, pr, pl;
    logic [DATA_W-1:0] pd;
    logic [W-1:0] e;
    hs_prev = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hs_prev = 1'b0;
        pv = 1'b0;
        en_ctr = 0;
      end else begin
        check("done_pulse", 32'(done), 32'(hs_prev));
        if (done) begin
          done_cnt++;
          en_ctr++;
          if (en_ctr == NUM_VALS) begin
            en_ctr = 0;
            en_y_cnt++;
          end
        end
        if (pv && !pr) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(pd));
          check("hold_last", 32'(out_last), 32'(pl));
        end
        check("busy_vs_valid", 32'(busy), 32'(out_valid));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[DATA_W-1:0]));
            check("out_last", 32'(out_last), 32'(e[DATA_W]));
          end
        end
        hs_prev = out_valid && out_ready;
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
        pl = out_last;
      end
    end
  end

  // Loads words base..base+NUM_VALS-1, queues them, and issues the start edge.
  task automatic start_burst(input int base);
    logic [W-1:0] e;
    for (int i = 0; i < NUM_VALS; i++) begin
      data_in[i*DATA_W +: DATA_W] = DATA_W'(base + i);
      e = {(i == NUM_VALS - 1), DATA_W'(base + i)};
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_valid", 32'(out_valid), 32'd1);
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0; 2: random ready, scrambled data_in.
  task automatic drain(input int mode, output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cycles % 3 == 0);
        default: begin
          out_ready = 1'($urandom_range(0, 1));
          data_in = {$urandom, $urandom, $urandom, $urandom};
        end
      endcase
      @(posedge clk);
      #1;
      cycles++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got busy=1 expected busy=0 after %0d cycles", cycles);
    end
  endtask

  initial begin
    int cyc, d0, e0;

    // Reset and reset-state checks
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic burst, one word per cycle
    d0 = done_cnt;
    start_burst(1);
    drain(0, cyc);
    check("burst_cycles", 32'(cyc), 32'd7);
    @(negedge clk);
    check("done_count_t1", 32'(done_cnt - d0), 32'd7);

    // 2: backpressure
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start_burst(1);
    drain(1, cyc);
    @(negedge clk);
    check("done_count_t2", 32'(done_cnt - d0), 32'd7);

    // 3: start while busy, mid-burst and on the final handshake
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start_burst(1);
    out_ready = 1'b1;
    for (int c = 1; c <= NUM_VALS; c++) begin
      if (c == 3 || c == 7) begin
        for (int i = 0; i < NUM_VALS; i++) data_in[i*DATA_W +: DATA_W] = DATA_W'(100 + i);
        start = 1'b1;
      end
      if (c == 7) check("busy_before_final", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("busy_after_final", 32'(busy), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("ignored_start", 32'(out_valid), 32'd0);
    end
    check("done_count_t3", 32'(done_cnt - d0), 32'd7);

    // 4: back-to-back bursts with start in the first IDLE cycle
    d0 = done_cnt;
    e0 = en_y_cnt;
    start_burst(1);
    drain(0, cyc);
    start_burst(8);
    drain(0, cyc);
    check("burst2_cycles", 32'(cyc), 32'd7);
    @(negedge clk);
    check("done_count_t4", 32'(done_cnt - d0), 32'd14);
    check("en_y_count_t4", 32'(en_y_cnt - e0), 32'd2);

    // 5: asynchronous reset after the third handshake
    @(posedge clk);
    #1;
    start_burst(1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_done", 32'(done), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start_burst(20);
    drain(0, cyc);
    @(negedge clk);
    check("done_count_t5", 32'(done_cnt - d0), 32'd7);

    // 6: data_in scrambled every cycle after capture
    @(posedge clk);
    #1;
    d0 = done_cnt;
    start_burst(30);
    drain(2, cyc);
    @(negedge clk);
    check("done_count_t6", 32'(done_cnt - d0), 32'd7);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
